// File: rtl/adder_arbiter_pkg.sv
// Shared constants and helpers for the adder arbiter: state encoding, index and
// hold-counter widths, and the flattened operand slice offset.
package adder_arbiter_pkg;

  localparam int unsigned DEF_N        = 8;
  localparam int unsigned DEF_R        = 2;
  localparam int unsigned DEF_MAX_HOLD = 0;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  // Grant index width, $clog2(R) but never below one bit.
  function automatic int unsigned idx_width(input int unsigned r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

  // Hold counter spans 0..MAX_HOLD-1; a 1-bit stub when unlimited.
  function automatic int unsigned hold_width(input int unsigned max_hold);
    return (max_hold > 1) ? $clog2(max_hold) : 1;
  endfunction

  // Low bit of requester r's 2N-bit operand slice in the flattened buses.
  function automatic int unsigned slice_lo(input int unsigned r, input int unsigned n);
    return r * 2 * n;
  endfunction

endpackage

// File: rtl/adder_arbiter_rr_picker.sv
// Combinational round-robin search: first requester at or after start (with wrap)
// that is requesting and not excluded.
module adder_arbiter_rr_picker
  import adder_arbiter_pkg::*;
#(
  parameter  int unsigned R  = DEF_R,
  localparam int unsigned IW = idx_width(R)
) (
  input  logic [R-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [R-1:0]  exclude,
  output logic [R-1:0]  winner,
  output logic          valid
);

  logic [R-1:0]  cand;
  logic [IW-1:0] idx;

  assign cand = req & ~exclude;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 0; k < int'(R); k++) begin
      idx = IW'((int'(start) + k) % int'(R));
      if (!valid && cand[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin owner arbiter for one shared 2N-bit adder. Registered one-hot grant,
// optional MAX_HOLD revocation, operand mux driven from the registered grant.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int unsigned N        = DEF_N,
  parameter int unsigned R        = DEF_R,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [R-1:0]       i_req,
  output logic [R-1:0]       o_grant,
  input  logic [R*2*N-1:0]   i_augend,
  input  logic [R*2*N-1:0]   i_addend,
  output logic [2*N-1:0]     o_sum,
  output logic [2*N-1:0]     o_adder_augend,
  output logic [2*N-1:0]     o_adder_addend,
  input  logic [2*N-1:0]     i_adder_sum,
  output logic               o_busy,
  output logic [R-1:0]       o_revoked
);

  localparam int unsigned IW        = idx_width(R);
  localparam int unsigned HW        = hold_width(MAX_HOLD);
  localparam int unsigned W         = 2 * N;
  localparam int unsigned HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  arb_state_e    state_q, state_d;
  logic [R-1:0]  grant_q, grant_d;
  logic [R-1:0]  revoked_q, revoked_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [IW-1:0] start;
  logic [R-1:0]  exclude;
  logic [R-1:0]  win_oh;
  logic          win_vld;
  logic [IW-1:0] win_idx;
  logic          owner_req;
  logic          expire;

  // ptr_q is the current owner while OWNED, so searching from ptr+1 covers both
  // fresh arbitration and hand-off; the owner itself is masked on hand-off.
  assign start     = (ptr_q == IW'(R - 1)) ? '0 : ptr_q + 1'b1;
  assign exclude   = (state_q == ARB_OWNED) ? grant_q : '0;
  assign owner_req = i_req[ptr_q];
  assign expire    = (MAX_HOLD != 0) && (state_q == ARB_OWNED) && owner_req &&
                     (hold_q == HW'(HOLD_LAST));

  adder_arbiter_rr_picker #(.R(R)) u_rr_picker (
    .req     (i_req),
    .start   (start),
    .exclude (exclude),
    .winner  (win_oh),
    .valid   (win_vld)
  );

  always_comb begin
    win_idx = '0;
    for (int r = 0; r < int'(R); r++)
      if (win_oh[r]) win_idx = IW'(r);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      revoked_q <= '0;
      ptr_q     <= IW'(R - 1);
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      revoked_q <= revoked_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    revoked_d = '0;
    case (state_q)
      ARB_IDLE: begin
        if (win_vld) begin
          state_d = ARB_OWNED;
          grant_d = win_oh;
          ptr_d   = win_idx;
          hold_d  = '0;
        end
      end
      ARB_OWNED: begin
        if (!owner_req || expire) begin
          if (expire) revoked_d = grant_q;
          hold_d = '0;
          if (win_vld) begin
            grant_d = win_oh;
            ptr_d   = win_idx;
          end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
          end
        end else if (MAX_HOLD != 0) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // AND-OR operand mux; grant is one-hot so at most one slice contributes.
  always_comb begin
    o_adder_augend = '0;
    o_adder_addend = '0;
    for (int r = 0; r < int'(R); r++) begin
      if (grant_q[r]) begin
        o_adder_augend = o_adder_augend | i_augend[slice_lo(r, N) +: W];
        o_adder_addend = o_adder_addend | i_addend[slice_lo(r, N) +: W];
      end
    end
  end

  assign o_sum     = i_adder_sum;
  assign o_grant   = grant_q;
  assign o_busy    = |grant_q;
  assign o_revoked = revoked_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: an unlimited-hold instance and a MAX_HOLD=4 instance
// share stimulus and are checked against an ownership-level reference model.
module tb_adder_arbiter;
  localparam int N = 8;
  localparam int R = 2;
  localparam int W = 2 * N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [R-1:0]   req;
  logic [R*W-1:0] aug, add;
  logic [R-1:0]   g0, g1, rv0, rv1;
  logic [W-1:0]   s0, s1, aa0, ad0, aa1, ad1, as0, as1;
  logic           b0, b1;

  assign as0 = aa0 + ad0;
  assign as1 = aa1 + ad1;

  adder_arbiter #(.N(N), .R(R), .MAX_HOLD(0)) dut (
    .i_clock(clk), .i_reset(rst), .i_req(req), .o_grant(g0),
    .i_augend(aug), .i_addend(add), .o_sum(s0),
    .o_adder_augend(aa0), .o_adder_addend(ad0), .i_adder_sum(as0),
    .o_busy(b0), .o_revoked(rv0));

  adder_arbiter #(.N(N), .R(R), .MAX_HOLD(4)) dut_h (
    .i_clock(clk), .i_reset(rst), .i_req(req), .o_grant(g1),
    .i_augend(aug), .i_addend(add), .o_sum(s1),
    .o_adder_augend(aa1), .o_adder_addend(ad1), .i_adder_sum(as1),
    .o_busy(b1), .o_revoked(rv1));

  int vec  = 0;
  int errs = 0;

  // Reference model: owner index (-1 = none), last owner, completed hold cycles.
  int           own [2];
  int           last[2];
  int           held[2];
  logic [R-1:0] erev[2];
  int           mw, mhv;
  bit           mrel, mexp;

  function automatic int pick(input logic [R-1:0] r, input int from, input int excl);
    for (int k = 1; k <= R; k++) begin
      int i;
      i = (from + k) % R;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      mhv = (m == 0) ? 0 : 4;
      if (rst) begin
        own[m] = -1; last[m] = R - 1; held[m] = 0; erev[m] = '0;
      end else begin
        erev[m] = '0;
        if (own[m] < 0) begin
          mw = pick(req, last[m], -1);
          if (mw >= 0) begin own[m] = mw; last[m] = mw; held[m] = 0; end
        end else begin
          held[m] = held[m] + 1;
          mrel = !req[own[m]];
          mexp = (mhv > 0) && !mrel && (held[m] >= mhv);
          if (mrel || mexp) begin
            if (mexp) erev[m][own[m]] = 1'b1;
            mw = pick(req, own[m], own[m]);
            own[m] = mw;
            if (mw >= 0) last[m] = mw;
            held[m] = 0;
          end
        end
      end
    end
  end

  function automatic logic [R-1:0] eg(input int m);
    logic [R-1:0] v;
    v = '0;
    if (own[m] >= 0) v[own[m]] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; req = '0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; aug = '0; add = '0;
    repeat (2) @(negedge clk);
    vec++; if (g0 !== 2'b00) begin errs++; $display("FAIL reset_grant: got %b want 00", g0); end
    vec++; if (g1 !== 2'b00) begin errs++; $display("FAIL reset_grant_h: got %b want 00", g1); end
    vec++; if (rv1 !== 2'b00) begin errs++; $display("FAIL reset_revoked: got %b want 00", rv1); end
    vec++; if (b0 !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", b0); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req = 2'b01; aug[0 +: W] = 16'h0003; add[0 +: W] = 16'h0004;
    #1;
    vec++; if (aa0 !== 16'h0000) begin errs++; $display("FAIL single_pregrant_operand: got %h want 0000", aa0); end
    vec++; if (g0 !== 2'b00) begin errs++; $display("FAIL single_pregrant: got %b want 00", g0); end
    @(negedge clk);
    vec++; if (g0 !== 2'b01) begin errs++; $display("FAIL single_grant: got %b want 01", g0); end
    vec++; if (aa0 !== 16'h0003) begin errs++; $display("FAIL single_augend: got %h want 0003", aa0); end
    vec++; if (ad0 !== 16'h0004) begin errs++; $display("FAIL single_addend: got %h want 0004", ad0); end
    vec++; if (s0 !== 16'h0007) begin errs++; $display("FAIL single_sum: got %h want 0007", s0); end
    vec++; if (b0 !== 1'b1) begin errs++; $display("FAIL single_busy: got %b want 1", b0); end
    req = 2'b00;
    @(negedge clk);
    vec++; if (g0 !== 2'b00) begin errs++; $display("FAIL single_release: got %b want 00", g0); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    req = 2'b11;
    @(negedge clk);
    vec++; if (g0 !== 2'b01) begin errs++; $display("FAIL simul_first: got %b want 01", g0); end
    req = 2'b10;
    @(negedge clk);
    vec++; if (g0 !== 2'b10) begin errs++; $display("FAIL simul_handoff: got %b want 10", g0); end
    req = 2'b00;
    @(negedge clk);
    vec++; if (g0 !== 2'b00) begin errs++; $display("FAIL simul_idle: got %b want 00", g0); end
  endtask

  task automatic test_fairness();
    int cnt[2]; bit drop[2]; logic [R-1:0] prev; logic [R-1:0] owners[$];
    cnt = '{0, 0}; drop = '{0, 0}; prev = '0;
    do_reset();
    req = 2'b11;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      vec++; if (g0 !== eg(0)) begin errs++; $display("FAIL fair_grant c%0d: got %b want %b", c, g0, eg(0)); end
      vec++; if (g1 !== eg(1)) begin errs++; $display("FAIL fair_grant_h c%0d: got %b want %b", c, g1, eg(1)); end
      if (g0 != 2'b00 && g0 != prev) owners.push_back(g0);
      prev = g0;
      for (int r = 0; r < R; r++) begin
        if (drop[r]) begin req[r] = 1'b1; drop[r] = 1'b0; end
        else if (g0[r]) begin
          cnt[r]++;
          if (cnt[r] == 3) begin req[r] = 1'b0; drop[r] = 1'b1; cnt[r] = 0; end
        end
      end
    end
    vec++; if (owners.size() < 6) begin errs++; $display("FAIL fair_turns: got %0d want >=6", owners.size()); end
    for (int i = 0; i < owners.size(); i++) begin
      vec++;
      if (owners[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errs++; $display("FAIL fair_order i%0d: got %b want %b", i, owners[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      end
    end
    req = 2'b00;
  endtask

  task automatic test_multiplier();
    logic [W-1:0] acc, mc; logic [7:0] mp;
    acc = '0; mc = 16'd13; mp = 8'd11;
    do_reset();
    req = 2'b01;
    @(negedge clk);
    vec++; if (g0 !== 2'b01) begin errs++; $display("FAIL mult_grant: got %b want 01", g0); end
    for (int i = 0; i < 8; i++) begin
      aug[0 +: W] = acc;
      add[0 +: W] = mp[i] ? (mc << i) : 16'h0000;
      req[1] = 1'b1;
      #1;
      acc = s0;
      vec++; if (g0 !== 2'b01) begin errs++; $display("FAIL mult_hold i%0d: got %b want 01", i, g0); end
      @(negedge clk);
    end
    vec++; if (acc !== 16'h008F) begin errs++; $display("FAIL mult_product: got %h want 008f", acc); end
    req[0] = 1'b0;
    @(negedge clk);
    vec++; if (g0 !== 2'b10) begin errs++; $display("FAIL mult_competitor: got %b want 10", g0); end
    req = 2'b00;
  endtask

  task automatic test_max_hold();
    logic [R-1:0] eg_t, er_t;
    do_reset();
    req = 2'b11;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      eg_t = (c <= 4) ? 2'b01 : 2'b10;
      er_t = (c == 5) ? 2'b01 : 2'b00;
      vec++; if (g1 !== eg_t) begin errs++; $display("FAIL hold_wait_grant c%0d: got %b want %b", c, g1, eg_t); end
      vec++; if (rv1 !== er_t) begin errs++; $display("FAIL hold_wait_revoked c%0d: got %b want %b", c, rv1, er_t); end
      vec++; if (g0 !== 2'b01) begin errs++; $display("FAIL hold_unlimited c%0d: got %b want 01", c, g0); end
    end
    do_reset();
    req = 2'b01;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      eg_t = (c == 5) ? 2'b00 : 2'b01;
      er_t = (c == 5) ? 2'b01 : 2'b00;
      vec++; if (g1 !== eg_t) begin errs++; $display("FAIL hold_alone_grant c%0d: got %b want %b", c, g1, eg_t); end
      vec++; if (rv1 !== er_t) begin errs++; $display("FAIL hold_alone_revoked c%0d: got %b want %b", c, rv1, er_t); end
    end
    req = 2'b00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 2'b11;
    @(negedge clk);
    req = 2'b10;
    @(negedge clk);
    vec++; if (g0 !== 2'b10) begin errs++; $display("FAIL rstmid_owner: got %b want 10", g0); end
    rst = 1'b1;
    @(negedge clk);
    vec++; if (g0 !== 2'b00) begin errs++; $display("FAIL rstmid_drop: got %b want 00", g0); end
    vec++; if (g1 !== 2'b00) begin errs++; $display("FAIL rstmid_drop_h: got %b want 00", g1); end
    rst = 1'b0; req = 2'b11;
    @(negedge clk);
    vec++; if (g0 !== 2'b01) begin errs++; $display("FAIL rstmid_restart: got %b want 01", g0); end
    req = 2'b00;
  endtask

  task automatic test_random();
    logic [W-1:0] ea, ed;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      ea = (own[0] >= 0) ? aug[own[0] * W +: W] : '0;
      ed = (own[0] >= 0) ? add[own[0] * W +: W] : '0;
      vec++; if (g0 !== eg(0)) begin errs++; $display("FAIL rnd_grant c%0d: got %b want %b", c, g0, eg(0)); end
      vec++; if (g1 !== eg(1)) begin errs++; $display("FAIL rnd_grant_h c%0d: got %b want %b", c, g1, eg(1)); end
      vec++; if (rv0 !== erev[0]) begin errs++; $display("FAIL rnd_revoked c%0d: got %b want %b", c, rv0, erev[0]); end
      vec++; if (rv1 !== erev[1]) begin errs++; $display("FAIL rnd_revoked_h c%0d: got %b want %b", c, rv1, erev[1]); end
      vec++; if (aa0 !== ea) begin errs++; $display("FAIL rnd_augend c%0d: got %h want %h", c, aa0, ea); end
      vec++; if (ad0 !== ed) begin errs++; $display("FAIL rnd_addend c%0d: got %h want %h", c, ad0, ed); end
      vec++; if (s0 !== W'(ea + ed)) begin errs++; $display("FAIL rnd_sum c%0d: got %h want %h", c, s0, W'(ea + ed)); end
      vec++; if (b1 !== (own[1] >= 0)) begin errs++; $display("FAIL rnd_busy_h c%0d: got %b want %b", c, b1, own[1] >= 0); end
      vec++; if ($countones(g1) > 1) begin errs++; $display("FAIL rnd_onehot c%0d: got %b want popcount<=1", c, g1); end
      rst = ($urandom_range(0, 59) == 0);
      for (int r = 0; r < R; r++)
        if ($urandom_range(0, 3) == 0) req[r] = ~req[r];
      aug = $urandom;
      add = $urandom;
    end
    rst = 1'b0; req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_multiplier();
    test_max_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
